// File: rtl/qpu_lsu_pkg.sv
// Shared sizing helpers for the LSU/DTCM datapath blocks.
package qpu_lsu_pkg;

   // Width of a channel index; a single channel still gets one bit.
   function automatic int calc_ch_w(input int n_ch);
      return (n_ch > 1) ? $clog2(n_ch) : 1;
   endfunction

   // Number of byte-offset bits dropped to form a word address.
   function automatic int calc_off(input int xlen);
      return (xlen > 8) ? $clog2(xlen / 8) : 0;
   endfunction

endpackage

// File: rtl/qpu_rsp_fifo.sv
// Synchronous response FIFO with occupancy output; push and pop may coincide even when full.
module qpu_rsp_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full || do_pop);
   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   // Next pointer and occupancy values, wrapping at DEPTH.
   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = (wr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
      if (do_pop)  rd_d = (rd_q == PTR_W'(DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
   end

   // Control state: pointers and occupancy, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // Entry storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/qpu_dtcm_mport_ctrl.sv
// Round-robin multi-channel front end for a single-port synchronous DTCM with in-order tagged responses.
module qpu_dtcm_mport_ctrl
   import qpu_lsu_pkg::*;
#(
   parameter int N_CH      = 2,
   parameter int XLEN      = 32,
   parameter int AW        = 32,
   parameter int DEPTH     = 1024,
   parameter int RSP_DEPTH = 4,
   localparam int RAM_AW   = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_CH-1:0]        cmd_valid,
   output logic [N_CH-1:0]        cmd_ready,
   input  logic [N_CH*AW-1:0]     cmd_addr,
   input  logic [N_CH-1:0]        cmd_read,
   input  logic [N_CH*XLEN-1:0]   cmd_wdata,
   input  logic [N_CH*XLEN/8-1:0] cmd_wmask,
   output logic [N_CH-1:0]        rsp_valid,
   input  logic [N_CH-1:0]        rsp_ready,
   output logic [XLEN-1:0]        rsp_rdata,
   output logic                   rsp_err,
   output logic                   ram_cs,
   output logic                   ram_we,
   output logic [RAM_AW-1:0]      ram_addr,
   output logic [XLEN/8-1:0]      ram_wem,
   output logic [XLEN-1:0]        ram_din,
   input  logic [XLEN-1:0]        ram_dout,
   output logic                   active
);

   localparam int CH_W  = calc_ch_w(N_CH);
   localparam int OFF   = calc_off(XLEN);
   localparam int BW    = XLEN / 8;
   localparam int CNT_W = $clog2(RSP_DEPTH + 1);
   localparam logic [AW:0]    ADDR_LIM   = (AW + 1)'(DEPTH * BW);
   localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W + 1)'(RSP_DEPTH);

   typedef struct packed {
      logic [CH_W-1:0] ch;
      logic [XLEN-1:0] rdata;
      logic            err;
   } rsp_entry_t;

   logic [CH_W-1:0]  ptr_q;
   logic [CH_W-1:0]  cand;
   logic [CH_W-1:0]  gnt_ch;
   logic             gnt_any;
   logic [AW-1:0]    g_addr;
   logic             g_err;
   logic             g_read;
   logic             credit;
   logic             hs;
   logic [CNT_W-1:0] fifo_cnt;
   logic [CNT_W:0]   cnt;
   logic             fifo_empty;
   logic             pop;
   logic             s1_vld_q;
   logic [CH_W-1:0]  s1_ch_q;
   logic             s1_read_q;
   logic             s1_err_q;
   rsp_entry_t       push_ent;
   rsp_entry_t       head;

   // Pick the first requesting channel at or after the round-robin pointer.
   always_comb begin
      gnt_any = 1'b0;
      gnt_ch  = '0;
      cand    = '0;
      for (int k = 0; k < N_CH; k++) begin
         cand = CH_W'((int'(ptr_q) + k) % N_CH);
         if (!gnt_any && cmd_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_ch  = cand;
         end
      end
   end

   // Credit excludes a same-cycle pop so cmd_ready never depends on rsp_ready.
   assign cnt       = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, s1_vld_q};
   assign credit    = (cnt < CREDIT_MAX);
   assign hs        = gnt_any && credit;
   assign cmd_ready = hs ? (N_CH'(1) << gnt_ch) : '0;

   assign g_addr   = cmd_addr[gnt_ch*AW +: AW];
   assign g_read   = cmd_read[gnt_ch];
   assign g_err    = ({1'b0, g_addr} >= ADDR_LIM);
   assign ram_cs   = hs && !g_err;
   assign ram_we   = hs && !g_err && !g_read;
   assign ram_addr = g_addr[RAM_AW+OFF-1:OFF];
   assign ram_wem  = cmd_wmask[gnt_ch*BW +: BW];
   assign ram_din  = cmd_wdata[gnt_ch*XLEN +: XLEN];

   // Arbiter pointer and s1 valid: advance past the winner on each handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q    <= '0;
         s1_vld_q <= 1'b0;
      end else begin
         s1_vld_q <= hs;
         if (hs) ptr_q <= (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
      end
   end

   // s1 payload, qualified by s1_vld_q so it needs no reset.
   always_ff @(posedge clk) begin
      if (hs) begin
         s1_ch_q   <= gnt_ch;
         s1_read_q <= g_read;
         s1_err_q  <= g_err;
      end
   end

   assign push_ent.ch    = s1_ch_q;
   assign push_ent.rdata = (s1_read_q && !s1_err_q) ? ram_dout : '0;
   assign push_ent.err   = s1_err_q;

   qpu_rsp_fifo #(
      .WIDTH($bits(rsp_entry_t)),
      .DEPTH(RSP_DEPTH)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (s1_vld_q),
      .din_i   (push_ent),
      .pop_i   (pop),
      .dout_o  (head),
      .count_o (fifo_cnt),
      .empty_o (fifo_empty)
   );

   assign pop       = !fifo_empty && rsp_ready[head.ch];
   assign rsp_valid = fifo_empty ? '0 : (N_CH'(1) << head.ch);
   assign rsp_rdata = fifo_empty ? '0 : head.rdata;
   assign rsp_err   = !fifo_empty && head.err;
   assign active    = (|cmd_valid) || s1_vld_q || !fifo_empty;

endmodule
